wb_sys_responder: RTL and testbench

//  Wishbone responder (target) for the ZAP ARM bus in core_3do. Decodes each CPU cycle to

---
 rtl/wb_sys_responder.sv | 208 ++++++++++++++++++++
 tb/tb_wb_sys_responder.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sys_responder.sv
// -----------------------------------------------------------------------------
// wb_sys_responder
//   Wishbone target for the ZAP ARM bus. Each CPU cycle is decoded to one of:
//   the SVF stub constants, the MADAM or CLIO register blocks (one-cycle rd/wr
//   strobes followed by REG_WS wait cycles), or the external memory port
//   (held request with a timeout). Every beat ends in a single-cycle wb_ack.
//
//   Ports
//     sys_clk, reset_n           clock, asynchronous active-low reset
//     wb_adr/dat_w/sel/we        CPU request fields
//     wb_cyc/stb/cti             CPU cycle control (cti: 000 classic,
//                                010 incrementing burst, 111 end of burst)
//     wb_dat_r, wb_ack           read data (valid with ack), beat acknowledge
//     madam_rd/wr, madam_dout    MADAM strobes (0x0330_xxxx) and read data
//     clio_rd/wr, clio_dout      CLIO strobes (0x0340_xxxx) and read data
//     mem_req/we/adr/sel/wdat    memory port request, held until completion
//     mem_rdat, mem_ack          memory read data and completion
//     timeout_evt                one-cycle pulse when a memory timeout fires
// -----------------------------------------------------------------------------
module wb_sys_responder #(
  parameter int unsigned REG_WS      = 1,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [31:0] TIMEOUT_DAT = 32'hDEADBEEF,
  parameter logic [31:0] SVF_DAT     = 32'hBADACCE5
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_w,
  input  logic [3:0]  wb_sel,
  input  logic        wb_we,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic [2:0]  wb_cti,
  output logic [31:0] wb_dat_r,
  output logic        wb_ack,
  output logic        madam_rd,
  output logic        madam_wr,
  input  logic [31:0] madam_dout,
  output logic        clio_rd,
  output logic        clio_wr,
  input  logic [31:0] clio_dout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_wdat,
  input  logic [31:0] mem_rdat,
  input  logic        mem_ack,
  output logic        timeout_evt
);

  localparam logic [7:0] REG_LAST = 8'(REG_WS);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REG,
    S_MEM,
    S_ACK
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic        madam_q;
  logic        accept;
  logic        dat_ld;
  logic [31:0] dat_nx;
  logic        madam_rd_nx, madam_wr_nx, clio_rd_nx, clio_wr_nx;
  logic        timeout_nx;
  logic        hit_svf2, hit_svf, hit_madam, hit_clio;

  // Burst and classic beats complete identically: the master supplies every
  // beat address and each beat passes through IDLE, so cti carries no state.
  logic unused_cti;
  assign unused_cti = ^wb_cti;

  assign hit_svf2  = (wb_adr == 32'h032002B4);
  assign hit_svf   = (wb_adr == 32'h03206100) || (wb_adr == 32'h03206900);
  assign hit_madam = (wb_adr[31:16] == 16'h0330);
  assign hit_clio  = (wb_adr[31:16] == 16'h0340);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    accept      = 1'b0;
    dat_ld      = 1'b0;
    dat_nx      = wb_dat_r;
    madam_rd_nx = 1'b0;
    madam_wr_nx = 1'b0;
    clio_rd_nx  = 1'b0;
    clio_wr_nx  = 1'b0;
    timeout_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (wb_cyc && wb_stb) begin
          accept = 1'b1;
          cnt_nx = '0;
          if (hit_svf2 || hit_svf) begin
            state_nx = S_ACK;
            if (!wb_we) begin
              dat_ld = 1'b1;
              dat_nx = hit_svf2 ? '0 : SVF_DAT;
            end
          end else if (hit_madam) begin
            state_nx    = S_REG;
            madam_rd_nx = !wb_we;
            madam_wr_nx = wb_we;
          end else if (hit_clio) begin
            state_nx   = S_REG;
            clio_rd_nx = !wb_we;
            clio_wr_nx = wb_we;
          end else begin
            state_nx = S_MEM;
          end
        end
      end
      S_REG: begin
        if (!wb_cyc) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (cnt == REG_LAST) begin
          state_nx = S_ACK;
          cnt_nx   = '0;
          if (!mem_we) begin
            dat_ld = 1'b1;
            dat_nx = madam_q ? madam_dout : clio_dout;
          end
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      S_MEM: begin
        // A completion in the same cycle as the timeout wins over it.
        if (!wb_cyc) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (mem_ack) begin
          state_nx = S_ACK;
          cnt_nx   = '0;
          if (!mem_we) begin
            dat_ld = 1'b1;
            dat_nx = mem_rdat;
          end
        end else if (cnt == TO_LAST) begin
          state_nx   = S_ACK;
          cnt_nx     = '0;
          timeout_nx = 1'b1;
          if (!mem_we) begin
            dat_ld = 1'b1;
            dat_nx = TIMEOUT_DAT;
          end
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      S_ACK: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so wb_ack/mem_req are flops.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      madam_q     <= 1'b0;
      wb_ack      <= 1'b0;
      wb_dat_r    <= '0;
      madam_rd    <= 1'b0;
      madam_wr    <= 1'b0;
      clio_rd     <= 1'b0;
      clio_wr     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_adr     <= '0;
      mem_sel     <= '0;
      mem_wdat    <= '0;
      timeout_evt <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      wb_ack      <= (state_nx == S_ACK);
      mem_req     <= (state_nx == S_MEM);
      madam_rd    <= madam_rd_nx;
      madam_wr    <= madam_wr_nx;
      clio_rd     <= clio_rd_nx;
      clio_wr     <= clio_wr_nx;
      timeout_evt <= timeout_nx;
      if (dat_ld) begin
        wb_dat_r <= dat_nx;
      end
      if (accept) begin
        mem_adr  <= wb_adr;
        mem_sel  <= wb_sel;
        mem_wdat <= wb_dat_w;
        mem_we   <= wb_we;
        madam_q  <= hit_madam;
      end
    end
  end

endmodule

// File: tb/tb_wb_sys_responder.sv
module tb_wb_sys_responder;

  localparam int unsigned REG_WS_P  = 1;
  localparam int unsigned TIMEOUT_P = 8;
  localparam logic [31:0] TDAT      = 32'hDEADBEEF;
  localparam logic [31:0] SDAT      = 32'hBADACCE5;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] wb_adr = '0, wb_dat_w = '0;
  logic [3:0]  wb_sel = '0;
  logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
  logic [2:0]  wb_cti = '0;
  logic [31:0] wb_dat_r;
  logic        wb_ack;
  logic        madam_rd, madam_wr, clio_rd, clio_wr;
  logic [31:0] madam_dout = '0, clio_dout = '0, mem_rdat = '0;
  logic        mem_req, mem_we, mem_ack = 1'b0, timeout_evt;
  logic [31:0] mem_adr, mem_wdat;
  logic [3:0]  mem_sel;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_rd = '0;

  wb_sys_responder #(
    .REG_WS(REG_WS_P), .TIMEOUT(TIMEOUT_P), .TIMEOUT_DAT(TDAT), .SVF_DAT(SDAT)
  ) dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_cti(wb_cti),
    .wb_dat_r(wb_dat_r), .wb_ack(wb_ack),
    .madam_rd(madam_rd), .madam_wr(madam_wr), .madam_dout(madam_dout),
    .clio_rd(clio_rd), .clio_wr(clio_wr), .clio_dout(clio_dout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_sel(mem_sel),
    .mem_wdat(mem_wdat), .mem_rdat(mem_rdat), .mem_ack(mem_ack),
    .timeout_evt(timeout_evt)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: 0 svf2, 1 svf, 2 madam, 3 clio, 4 memory.
  function automatic int exp_class(input logic [31:0] a);
    if (a == 32'h032002B4) return 0;
    if (a == 32'h03206100 || a == 32'h03206900) return 1;
    if (a >= 32'h03300000 && a <= 32'h0330FFFF) return 2;
    if (a >= 32'h03400000 && a <= 32'h0340FFFF) return 3;
    return 4;
  endfunction

  function automatic logic [31:0] all_outs_or();
    return {31'd0, wb_ack | madam_rd | madam_wr | clio_rd | clio_wr | mem_req |
            mem_we | timeout_evt} | wb_dat_r | mem_adr | {28'd0, mem_sel} | mem_wdat;
  endfunction

  // Drives one transaction starting at cycle 0 (called 1 unit after posedge).
  // mem_lat: mem_ack in the mem_lat-th cycle of mem_req (0 = never).
  // abort_at: cycle in which cyc drops (-1 = none); a late mem_ack follows it.
  task automatic run_txn(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                         input logic [3:0] sel, input int mem_lat, input int abort_at,
                         output int ack_k, output int ack_n, output logic [31:0] rdat,
                         output int mrd_n, output int mwr_n, output int crd_n,
                         output int cwr_n, output int strb_k, output int req_n,
                         output int tevt_n, output int tevt_k, output int lat_bad);
    int seen;
    int stop_k;
    ack_k = -1; ack_n = 0; rdat = '0; mrd_n = 0; mwr_n = 0; crd_n = 0; cwr_n = 0;
    strb_k = -1; req_n = 0; tevt_n = 0; tevt_k = -1; lat_bad = 0; seen = 0;
    stop_k = (abort_at >= 0) ? abort_at + 10 : 40;
    wb_adr = adr; wb_we = we; wb_dat_w = wd; wb_sel = sel; wb_cti = 3'b000;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    for (int k = 0; k <= stop_k; k++) begin
      if (abort_at >= 0 && k == abort_at) begin
        wb_cyc = 1'b0; wb_stb = 1'b0;
      end
      if (mem_req) seen++;
      mem_ack = 1'b0;
      if (abort_at >= 0 && k == abort_at + 1) mem_ack = 1'b1;
      else if (mem_req && mem_lat > 0 && seen == mem_lat) mem_ack = 1'b1;
      @(negedge sys_clk);
      if (wb_ack) begin
        ack_n++;
        if (ack_k < 0) begin
          ack_k = k; rdat = wb_dat_r;
          if (abort_at < 0) stop_k = k + 3;
        end
      end
      if (madam_rd) begin mrd_n++; if (strb_k < 0) strb_k = k; end
      if (madam_wr) begin mwr_n++; if (strb_k < 0) strb_k = k; end
      if (clio_rd)  begin crd_n++; if (strb_k < 0) strb_k = k; end
      if (clio_wr)  begin cwr_n++; if (strb_k < 0) strb_k = k; end
      if (mem_req) begin
        req_n++;
        if (mem_adr !== adr || mem_we !== we || mem_wdat !== wd || mem_sel !== sel) lat_bad++;
      end
      if (timeout_evt) begin tevt_n++; if (tevt_k < 0) tevt_k = k; end
      @(posedge sys_clk); #1;
      if (ack_k >= 0 && k == ack_k) begin
        wb_cyc = 1'b0; wb_stb = 1'b0;
      end
    end
    mem_ack = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    n_tests++;
    if (all_outs_or() !== 32'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_outs_or());
    end
    n_tests++;
    if (wb_ack !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_ack_req: got %b%b expected 00", wb_ack, mem_req);
    end
    reset_n = 1'b1;
    @(posedge sys_clk); #1;
    last_rd = '0;
  endtask

  task automatic test_madam_read;
    int ak, an, mr, mw, cr, cw, sk, rq, tn, tk, lb;
    logic [31:0] rd;
    madam_dout = 32'h12345678;
    run_txn(32'h03300004, 1'b0, 32'h0, 4'hF, 0, -1, ak, an, rd, mr, mw, cr, cw, sk, rq, tn, tk, lb);
    last_rd = 32'h12345678;
    n_tests++;
    if (ak !== 3 || an !== 1) begin
      n_fail++; $display("FAIL madam_rd_ack: got cycle %0d count %0d expected 3/1", ak, an);
    end
    n_tests++;
    if (rd !== 32'h12345678) begin
      n_fail++; $display("FAIL madam_rd_data: got %h expected 12345678", rd);
    end
    n_tests++;
    if (mr !== 1 || sk !== 1 || mw + cr + cw + rq !== 0) begin
      n_fail++; $display("FAIL madam_rd_strobe: got n=%0d at %0d others %0d expected 1 at 1, 0",
                         mr, sk, mw + cr + cw + rq);
    end
  endtask

  task automatic test_clio_write;
    int ak, an, mr, mw, cr, cw, sk, rq, tn, tk, lb;
    logic [31:0] rd;
    clio_dout = 32'h0F0F0F0F;
    run_txn(32'h03400040, 1'b1, 32'hA5A5A5A5, 4'hF, 0, -1, ak, an, rd, mr, mw, cr, cw, sk, rq, tn, tk, lb);
    n_tests++;
    if (ak !== 3 || an !== 1) begin
      n_fail++; $display("FAIL clio_wr_ack: got cycle %0d count %0d expected 3/1", ak, an);
    end
    n_tests++;
    if (cw !== 1 || sk !== 1 || mr + mw + cr !== 0) begin
      n_fail++; $display("FAIL clio_wr_strobe: got n=%0d at %0d others %0d expected 1 at 1, 0",
                         cw, sk, mr + mw + cr);
    end
    n_tests++;
    if (rd !== last_rd || mem_wdat !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL clio_wr_hold: got dat_r %h wdat %h expected %h / a5a5a5a5",
                         rd, mem_wdat, last_rd);
    end
  endtask

  task automatic test_svf;
    int ak, an, mr, mw, cr, cw, sk, rq, tn, tk, lb;
    logic [31:0] rd;
    run_txn(32'h03206100, 1'b0, 32'h0, 4'hF, 0, -1, ak, an, rd, mr, mw, cr, cw, sk, rq, tn, tk, lb);
    n_tests++;
    if (ak !== 1 || rd !== SDAT) begin
      n_fail++; $display("FAIL svf_6100: got cycle %0d data %h expected 1 / %h", ak, rd, SDAT);
    end
    run_txn(32'h03206900, 1'b0, 32'h0, 4'hF, 0, -1, ak, an, rd, mr, mw, cr, cw, sk, rq, tn, tk, lb);
    n_tests++;
    if (ak !== 1 || rd !== SDAT) begin
      n_fail++; $display("FAIL svf_6900: got cycle %0d data %h expected 1 / %h", ak, rd, SDAT);
    end
    run_txn(32'h032002B4, 1'b0, 32'h0, 4'hF, 0, -1, ak, an, rd, mr, mw, cr, cw, sk, rq, tn, tk, lb);
    last_rd = '0;
    n_tests++;
    if (ak !== 1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL svf2_read: got cycle %0d data %h expected 1 / 0", ak, rd);
    end
    run_txn(32'h032002B4, 1'b1, 32'h11111111, 4'hF, 0, -1, ak, an, rd, mr, mw, cr, cw, sk, rq, tn, tk, lb);
    n_tests++;
    if (ak !== 1 || an !== 1 || mr + mw + cr + cw + rq !== 0 || rd !== 32'h0) begin
      n_fail++; $display("FAIL svf2_write: got cycle %0d n %0d side %0d data %h expected 1/1/0/0",
                         ak, an, mr + mw + cr + cw + rq, rd);
    end
  endtask

  task automatic test_mem;
    int ak, an, mr, mw, cr, cw, sk, rq, tn, tk, lb;
    logic [31:0] rd;
    mem_rdat = 32'hCAFEF00D;
    run_txn(32'h00000100, 1'b0, 32'h0, 4'h3, 5, -1, ak, an, rd, mr, mw, cr, cw, sk, rq, tn, tk, lb);
    last_rd = 32'hCAFEF00D;
    n_tests++;
    if (rq !== 5 || ak !== 6 || rd !== 32'hCAFEF00D || tn !== 0 || lb !== 0) begin
      n_fail++; $display("FAIL mem_read: got req %0d ack %0d data %h tevt %0d bad %0d expected 5/6/cafef00d/0/0",
                         rq, ak, rd, tn, lb);
    end
    run_txn(32'h00000200, 1'b0, 32'h0, 4'hF, 0, -1, ak, an, rd, mr, mw, cr, cw, sk, rq, tn, tk, lb);
    last_rd = TDAT;
    n_tests++;
    if (rq !== TIMEOUT_P || ak !== TIMEOUT_P + 1 || rd !== TDAT) begin
      n_fail++; $display("FAIL mem_timeout: got req %0d ack %0d data %h expected %0d/%0d/%h",
                         rq, ak, rd, TIMEOUT_P, TIMEOUT_P + 1, TDAT);
    end
    n_tests++;
    if (tn !== 1 || tk !== ak) begin
      n_fail++; $display("FAIL mem_timeout_evt: got n %0d at %0d expected 1 at %0d", tn, tk, ak);
    end
    mem_rdat = 32'h600DF00D;
    run_txn(32'h00000300, 1'b0, 32'h0, 4'hF, TIMEOUT_P, -1, ak, an, rd, mr, mw, cr, cw, sk, rq, tn, tk, lb);
    last_rd = 32'h600DF00D;
    n_tests++;
    if (ak !== TIMEOUT_P + 1 || rd !== 32'h600DF00D || tn !== 0) begin
      n_fail++; $display("FAIL mem_ack_at_limit: got ack %0d data %h tevt %0d expected %0d/600df00d/0",
                         ak, rd, tn, TIMEOUT_P + 1);
    end
    run_txn(32'h00000404, 1'b1, 32'h13572468, 4'h5, 0, -1, ak, an, rd, mr, mw, cr, cw, sk, rq, tn, tk, lb);
    n_tests++;
    if (ak !== TIMEOUT_P + 1 || rd !== last_rd || tn !== 1 || lb !== 0) begin
      n_fail++; $display("FAIL mem_write_timeout: got ack %0d data %h tevt %0d bad %0d expected %0d/%h/1/0",
                         ak, rd, tn, lb, TIMEOUT_P + 1, last_rd);
    end
  endtask

  task automatic test_burst;
    logic [31:0] adrs [4];
    logic [31:0] dats [4];
    logic [2:0]  ctis [4];
    int beat, acks, adjacent, last_k, seen, stop_k;
    bit prev_ack;
    logic [31:0] base;
    base = 32'h00002000 + ($urandom & 32'h000FFF00);
    for (int i = 0; i < 4; i++) begin
      adrs[i] = base + 32'(i * 4);
      dats[i] = $urandom;
      ctis[i] = (i == 3) ? 3'b111 : 3'b010;
    end
    beat = 0; acks = 0; adjacent = 0; last_k = -1; seen = 0; prev_ack = 1'b0; stop_k = 60;
    wb_adr = adrs[0]; wb_cti = ctis[0]; mem_rdat = dats[0]; wb_we = 1'b0; wb_sel = 4'hF;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    for (int k = 0; k <= stop_k; k++) begin
      if (mem_req) seen++; else seen = 0;
      mem_ack = mem_req && (seen == 1);
      @(negedge sys_clk);
      if (wb_ack) begin
        if (prev_ack) adjacent++;
        acks++; last_k = k;
        n_tests++;
        if (beat > 3 || wb_dat_r !== dats[beat]) begin
          n_fail++; $display("FAIL burst_data: beat %0d got %h expected %h", beat, wb_dat_r,
                             dats[beat & 3]);
        end
      end
      if (mem_req && mem_adr !== wb_adr) begin
        n_tests++; n_fail++;
        $display("FAIL burst_adr: got %h expected %h", mem_adr, wb_adr);
      end
      prev_ack = wb_ack;
      @(posedge sys_clk); #1;
      if (last_k == k) begin
        beat++;
        if (beat >= 4) begin
          wb_cyc = 1'b0; wb_stb = 1'b0;
          if (stop_k > k + 3) stop_k = k + 3;
        end else begin
          wb_adr = adrs[beat]; wb_cti = ctis[beat]; mem_rdat = dats[beat];
        end
      end
    end
    mem_ack = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_cti = 3'b000;
    last_rd = dats[3];
    n_tests++;
    if (acks !== 4 || adjacent !== 0 || last_k !== 11) begin
      n_fail++; $display("FAIL burst_acks: got %0d acks %0d adjacent last %0d expected 4/0/11",
                         acks, adjacent, last_k);
    end
  endtask

  task automatic test_abort;
    int ak, an, mr, mw, cr, cw, sk, rq, tn, tk, lb;
    logic [31:0] rd;
    mem_rdat = 32'h0BADBAD0;
    run_txn(32'h00000400, 1'b0, 32'h0, 4'hF, 0, 3, ak, an, rd, mr, mw, cr, cw, sk, rq, tn, tk, lb);
    n_tests++;
    if (an !== 0 || rq !== 3 || tn !== 0 || wb_dat_r !== last_rd) begin
      n_fail++; $display("FAIL abort_mem: got acks %0d req %0d tevt %0d dat %h expected 0/3/0/%h",
                         an, rq, tn, wb_dat_r, last_rd);
    end
    mem_rdat = 32'h77665544;
    run_txn(32'h00000500, 1'b0, 32'h0, 4'hF, TIMEOUT_P, -1, ak, an, rd, mr, mw, cr, cw, sk, rq, tn, tk, lb);
    last_rd = 32'h77665544;
    n_tests++;
    if (ak !== TIMEOUT_P + 1 || tn !== 0 || rd !== 32'h77665544) begin
      n_fail++; $display("FAIL abort_counter_clear: got ack %0d tevt %0d data %h expected %0d/0/77665544",
                         ak, tn, rd, TIMEOUT_P + 1);
    end
    madam_dout = 32'h99999999;
    run_txn(32'h03300010, 1'b0, 32'h0, 4'hF, 0, 1, ak, an, rd, mr, mw, cr, cw, sk, rq, tn, tk, lb);
    n_tests++;
    if (an !== 0 || mr !== 1 || wb_dat_r !== last_rd) begin
      n_fail++; $display("FAIL abort_reg: got acks %0d strobes %0d dat %h expected 0/1/%h",
                         an, mr, wb_dat_r, last_rd);
    end
  endtask

  task automatic test_reset_mid;
    int acks;
    wb_adr = 32'h03300020; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge sys_clk); #1;
    n_tests++;
    if (madam_rd !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_pre: got madam_rd %b expected 1", madam_rd);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (all_outs_or() !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %h expected 0", all_outs_or());
    end
    @(posedge sys_clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; reset_n = 1'b1;
    acks = 0;
    repeat (5) begin
      @(negedge sys_clk);
      if (wb_ack) acks++;
    end
    @(posedge sys_clk); #1;
    last_rd = '0;
    n_tests++;
    if (acks !== 0 || wb_dat_r !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_after: got acks %0d dat %h expected 0/0", acks, wb_dat_r);
    end
  endtask

  task automatic test_random;
    int ak, an, mr, mw, cr, cw, sk, rq, tn, tk, lb;
    int cls, lat, e_k, e_req;
    bit e_to;
    logic [31:0] rd, adr, wd, e_dat;
    logic [3:0] sel;
    logic we;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(4, 0))
        0: adr = 32'h032002B4;
        1: adr = $urandom_range(1, 0) ? 32'h03206100 : 32'h03206900;
        2: adr = 32'h03300000 | ($urandom & 32'h0000FFFC);
        3: adr = 32'h03400000 | ($urandom & 32'h0000FFFC);
        default: adr = $urandom & 32'h00FFFFFC;
      endcase
      we = 1'($urandom); wd = $urandom; sel = 4'($urandom);
      lat = $urandom_range(TIMEOUT_P + 3, 0);
      madam_dout = $urandom; clio_dout = $urandom; mem_rdat = $urandom;
      cls = exp_class(adr);
      e_to = (cls == 4) && (lat < 1 || lat > TIMEOUT_P);
      e_req = (cls != 4) ? 0 : (e_to ? TIMEOUT_P : lat);
      e_k = (cls <= 1) ? 1 : (cls <= 3) ? 2 + REG_WS_P : e_req + 1;
      if (we) e_dat = last_rd;
      else case (cls)
        0: e_dat = '0;
        1: e_dat = SDAT;
        2: e_dat = madam_dout;
        3: e_dat = clio_dout;
        default: e_dat = e_to ? TDAT : mem_rdat;
      endcase
      run_txn(adr, we, wd, sel, lat, -1, ak, an, rd, mr, mw, cr, cw, sk, rq, tn, tk, lb);
      last_rd = e_dat;
      n_tests++;
      if (ak !== e_k || an !== 1 || rd !== e_dat) begin
        n_fail++; $display("FAIL rand_txn %0d adr %h we %b: got ack %0d n %0d data %h expected %0d/1/%h",
                           t, adr, we, ak, an, rd, e_k, e_dat);
      end
      n_tests++;
      if (mr !== int'(cls == 2 && !we) || mw !== int'(cls == 2 && we) ||
          cr !== int'(cls == 3 && !we) || cw !== int'(cls == 3 && we) ||
          sk !== ((cls == 2 || cls == 3) ? 1 : -1)) begin
        n_fail++; $display("FAIL rand_strobe %0d adr %h: got %0d%0d%0d%0d at %0d class %0d we %b",
                           t, adr, mr, mw, cr, cw, sk, cls, we);
      end
      n_tests++;
      if (rq !== e_req || tn !== int'(e_to) || lb !== 0) begin
        n_fail++; $display("FAIL rand_mem %0d adr %h: got req %0d tevt %0d bad %0d expected %0d/%0d/0",
                           t, adr, rq, tn, lb, e_req, e_to);
      end
    end
  endtask

  initial begin
    test_reset();
    test_madam_read();
    test_clio_write();
    test_svf();
    test_mem();
    test_burst();
    test_abort();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
